psr_cond_unit: RTL and testbench

- Holds the processor status register (PSR) flags C, L, F, Z, N.
- Evaluates the 4-bit branch condition code for BCOND/JCOND and drives the control FSM's `conditional` input.
- Sits beside the control FSM, between the ALU flag outputs and the FSM. It consumes the FSM's `psrbit` (flag write) and `opcodebit` (fetch strobe) and produces `conditional`, which stays stable for the whole instruction.

---
 rtl/psr_cond_unit.sv | 83 ++++++++
 tb/tb_psr_cond_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/psr_cond_unit.sv
// Purpose: holds the PSR flags {N,Z,F,L,C} and turns the branch condition code into a registered taken bit.
// Latency: flags update on the edge where psr_write is high; conditional/cond_valid are valid one edge after cond_eval.
// Backpressure: none; every strobe is accepted on the cycle it is asserted.
module psr_cond_unit #(
  parameter int NFLAGS = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch,
  input  logic              psr_write,
  input  logic [NFLAGS-1:0] flag_mask,
  input  logic [NFLAGS-1:0] alu_flags,
  input  logic              cond_eval,
  input  logic              is_branch,
  input  logic [3:0]        cond_code,
  output logic [NFLAGS-1:0] flags,
  output logic              conditional,
  output logic              cond_valid
);

  // Bit positions inside the PSR.
  localparam int C_BIT = 0;
  localparam int L_BIT = 1;
  localparam int F_BIT = 2;
  localparam int Z_BIT = 3;
  localparam int N_BIT = 4;

  logic flag_c, flag_l, flag_f, flag_z, flag_n;
  logic cond_true;

  assign flag_c = flags[C_BIT];
  assign flag_l = flags[L_BIT];
  assign flag_f = flags[F_BIT];
  assign flag_z = flags[Z_BIT];
  assign flag_n = flags[N_BIT];

  // Condition table evaluated on the registered flags, so a same-cycle flag write is not seen.
  always_comb begin
    cond_true = 1'b0;
    case (cond_code)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = !flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = !flag_c;
      4'b0100: cond_true = flag_l;
      4'b0101: cond_true = !flag_l;
      4'b0110: cond_true = flag_n;
      4'b0111: cond_true = !flag_n;
      4'b1000: cond_true = flag_f;
      4'b1001: cond_true = !flag_f;
      4'b1010: cond_true = !flag_l && !flag_z;
      4'b1011: cond_true = flag_l || flag_z;
      4'b1100: cond_true = !flag_n && !flag_z;
      4'b1101: cond_true = flag_n || flag_z;
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // PSR register: masked per-bit write, otherwise hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else if (psr_write) begin
      flags <= (flag_mask & alu_flags) | (~flag_mask & flags);
    end
  end

  // Branch-taken latch: fetch clears it for the new instruction and beats a same-cycle evaluation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conditional <= 1'b0;
      cond_valid  <= 1'b0;
    end else if (fetch) begin
      conditional <= 1'b0;
      cond_valid  <= 1'b0;
    end else if (cond_eval) begin
      conditional <= is_branch && cond_true;
      cond_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psr_cond_unit.sv
// Directed bench for psr_cond_unit: stimulus pushes expected outputs into a queue,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_psr_cond_unit;

  logic       clock;
  logic       reset;
  logic       fetch;
  logic       psr_write;
  logic [4:0] flag_mask;
  logic [4:0] alu_flags;
  logic       cond_eval;
  logic       is_branch;
  logic [3:0] cond_code;
  logic [4:0] flags;
  logic       conditional;
  logic       cond_valid;

  typedef struct {
    string      name;
    logic [4:0] f;
    logic       c;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [4:0] exp_flags;

  psr_cond_unit #(.NFLAGS(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch       (fetch),
    .psr_write   (psr_write),
    .flag_mask   (flag_mask),
    .alu_flags   (alu_flags),
    .cond_eval   (cond_eval),
    .is_branch   (is_branch),
    .cond_code   (cond_code),
    .flags       (flags),
    .conditional (conditional),
    .cond_valid  (cond_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every pending expectation is compared at the falling edge.
  always @(negedge clock) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (flags !== e.f || conditional !== e.c || cond_valid !== e.v) begin
        errors++;
        $display("FAIL %s: got flags=%b cond=%b vld=%b, expected flags=%b cond=%b vld=%b",
                 e.name, flags, conditional, cond_valid, e.f, e.c, e.v);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [4:0] f, input logic c, input logic v);
    exp_t e;
    e.name = name;
    e.f    = f;
    e.c    = c;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  task automatic write_all(input logic [4:0] val);
    psr_write = 1'b1;
    flag_mask = 5'b11111;
    alu_flags = val;
    cyc();
    psr_write = 1'b0;
    flag_mask = 5'b00000;
    exp_flags = val;
  endtask

  task automatic eval(input logic br, input logic [3:0] cc);
    cond_eval = 1'b1;
    is_branch = br;
    cond_code = cc;
    cyc();
    cond_eval = 1'b0;
    is_branch = 1'b0;
  endtask

  task automatic do_fetch();
    fetch = 1'b1;
    cyc();
    fetch = 1'b0;
  endtask

  // Hand-computed condition results, bit i = result for cond_code i.
  logic [4:0]  pat [4];
  logic [15:0] vec [4];

  initial begin
    pat[0] = 5'b00000; vec[0] = 16'h56AA;
    pat[1] = 5'b11111; vec[1] = 16'h6955;
    pat[2] = 5'b01000; vec[2] = 16'h6AA9;
    pat[3] = 5'b10000; vec[3] = 16'h666A;

    reset = 1'b0; fetch = 1'b0; psr_write = 1'b0; flag_mask = '0; alu_flags = '0;
    cond_eval = 1'b0; is_branch = 1'b0; cond_code = '0; exp_flags = '0;

    // Reset state while clocks toggle.
    cyc(); cyc();
    expect_out("reset_state", 5'b00000, 1'b0, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();

    // Masked write, then hold.
    psr_write = 1'b1; flag_mask = 5'b01010; alu_flags = 5'b11111;
    cyc();
    psr_write = 1'b0; flag_mask = 5'b00000; alu_flags = 5'b00000;
    expect_out("masked_write", 5'b01010, 1'b0, 1'b0);
    cyc();
    expect_out("flags_hold", 5'b01010, 1'b0, 1'b0);

    // Zero mask with write enabled leaves flags alone.
    psr_write = 1'b1; flag_mask = 5'b00000; alu_flags = 5'b10101;
    cyc();
    psr_write = 1'b0;
    expect_out("zero_mask", 5'b01010, 1'b0, 1'b0);

    // Condition sweep over four flag patterns.
    for (int p = 0; p < 4; p++) begin
      logic [15:0] v;
      v = vec[p];
      write_all(pat[p]);
      for (int cc = 0; cc < 16; cc++) begin
        eval(1'b1, 4'(cc));
        expect_out($sformatf("sweep_p%0d_cc%0d", p, cc), pat[p], v[cc], 1'b1);
      end
    end

    // Non-branch never takes, even on UC.
    do_fetch();
    expect_out("fetch_clear", exp_flags, 1'b0, 1'b0);
    eval(1'b0, 4'b1110);
    expect_out("nonbranch_uc", exp_flags, 1'b0, 1'b1);

    // Hold across flag writes, then clear on fetch.
    do_fetch();
    write_all(5'b01000);
    eval(1'b1, 4'b0000);
    expect_out("hold_eval_eq", 5'b01000, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      psr_write = 1'b1; flag_mask = 5'b01000; alu_flags = 5'b00000;
      cyc();
      expect_out($sformatf("hold_cycle%0d", k), 5'b00000, 1'b1, 1'b1);
    end
    psr_write = 1'b0; flag_mask = 5'b00000;
    do_fetch();
    expect_out("hold_fetch_clear", 5'b00000, 1'b0, 1'b0);

    // Write Z together with EQ evaluation: old flags are used.
    psr_write = 1'b1; flag_mask = 5'b01000; alu_flags = 5'b01000;
    cond_eval = 1'b1; is_branch = 1'b1; cond_code = 4'b0000;
    cyc();
    psr_write = 1'b0; flag_mask = 5'b00000; cond_eval = 1'b0; is_branch = 1'b0;
    expect_out("collide_write_eval", 5'b01000, 1'b0, 1'b1);
    // Re-evaluation before fetch sees the new flags.
    eval(1'b1, 4'b0000);
    expect_out("reeval_last_wins", 5'b01000, 1'b1, 1'b1);

    // Fetch beats evaluation; a same-cycle flag write still lands.
    fetch = 1'b1; cond_eval = 1'b1; is_branch = 1'b1; cond_code = 4'b1110;
    psr_write = 1'b1; flag_mask = 5'b00001; alu_flags = 5'b00001;
    cyc();
    fetch = 1'b0; cond_eval = 1'b0; is_branch = 1'b0; psr_write = 1'b0; flag_mask = 5'b00000;
    expect_out("collide_fetch_eval", 5'b01001, 1'b0, 1'b0);

    // Asynchronous reset mid-instruction with conditional high.
    eval(1'b1, 4'b1110);
    expect_out("pre_async_reset", 5'b01001, 1'b1, 1'b1);
    @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    expect_out("async_reset", 5'b00000, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    cyc();
    expect_out("after_reset_release", 5'b00000, 1'b0, 1'b0);

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: stimulus still running at %0t, expected done", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
